bw_dot_accum: RTL

BW_DOT_ACCUM -- requirements
Module: bw_dot_accum

---
 rtl/bw_pkg.sv | 15 +
 rtl/baugh_wooley.sv | 39 +++
 rtl/bw_dot_accum.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bw_pkg.sv
// Shared FSM state type and width helper for the Baugh-Wooley dot-product accumulator.
package bw_pkg;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } bw_state_e;

    // Product width plus enough guard bits that p_len worst-case products cannot overflow.
    function automatic int acc_width(input int width, input int len);
        return 2 * width + $clog2(len);
    endfunction

endpackage

// File: rtl/baugh_wooley.sv
// Combinational signed multiplier built from a Baugh-Wooley partial-product array.
module baugh_wooley #(
    parameter int p_width = 8
) (
    input  logic signed [p_width-1:0]   a_i,
    input  logic signed [p_width-1:0]   b_i,
    output logic signed [2*p_width-1:0] product_o
);

    logic [2*p_width-1:0] sum;
    logic [2*p_width-1:0] term;
    logic                 pp;

    // Partial products that pair exactly one sign bit with a magnitude bit are inverted,
    // and the two correction constants at bits p_width and 2*p_width-1 restore the sign.
    always_comb begin
        sum  = '0;
        term = '0;
        pp   = 1'b0;
        for (int i = 0; i < p_width; i++) begin
            for (int j = 0; j < p_width; j++) begin
                pp = a_i[i] & b_i[j];
                if ((i == p_width - 1) != (j == p_width - 1)) begin
                    pp = ~pp;
                end
                term        = '0;
                term[i + j] = pp;
                sum         = sum + term;
            end
        end
        term                = '0;
        term[p_width]       = 1'b1;
        term[2*p_width - 1] = 1'b1;
        sum                 = sum + term;
    end

    assign product_o = sum;

endmodule

// File: rtl/bw_dot_accum.sv
// Streaming signed dot-product engine: one registered term per cycle feeds a single
// Baugh-Wooley multiplier whose product is added into a full-width accumulator.
module bw_dot_accum
    import bw_pkg::*;
#(
    parameter int p_width = 8,
    parameter int p_len   = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       clear_i,
    input  logic                                       valid_i,
    output logic                                       ready_o,
    input  logic signed [p_width-1:0]                  a_i,
    input  logic signed [p_width-1:0]                  b_i,
    output logic                                       valid_o,
    input  logic                                       ready_i,
    output logic signed [acc_width(p_width, p_len)-1:0] acc_o
);

    localparam int AccW = acc_width(p_width, p_len);
    localparam int ExtW = AccW - 2 * p_width;
    localparam int CntW = $clog2(p_len + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(p_len - 1);

    bw_state_e                  state_q, state_d;
    logic [CntW-1:0]            count_q, count_d;
    logic signed [AccW-1:0]     acc_q, acc_d;
    logic                       op_valid_q, op_valid_d;
    logic signed [p_width-1:0]  op_a_q, op_a_d;
    logic signed [p_width-1:0]  op_b_q, op_b_d;
    logic                       ready_q, ready_d;
    logic                       valid_q, valid_d;
    logic signed [2*p_width-1:0] product;
    logic signed [AccW-1:0]     product_ext;

    baugh_wooley #(.p_width(p_width)) u_mult (
        .a_i       (op_a_q),
        .b_i       (op_b_q),
        .product_o (product)
    );

    assign product_ext = {{ExtW{product[2*p_width-1]}}, product};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        op_valid_d = 1'b0;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;

        // The product of the previously captured term lands regardless of state.
        if (op_valid_q) begin
            acc_d = acc_q + product_ext;
        end

        case (state_q)
            S_ACC: begin
                if (valid_i) begin
                    op_a_d     = a_i;
                    op_b_d     = b_i;
                    op_valid_d = 1'b1;
                    count_d    = count_q + CntW'(1);
                    if (count_q == LastCnt) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (ready_i) begin
                    state_d = S_ACC;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase

        if (clear_i) begin
            state_d    = S_ACC;
            count_d    = '0;
            acc_d      = '0;
            op_valid_d = 1'b0;
        end

        ready_d = (state_d == S_ACC);
        valid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_ACC;
            count_q    <= '0;
            acc_q      <= '0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign acc_o   = acc_q;

endmodule
